// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces scanner key codes, then edits a 4-digit BCD
// entry buffer (digits, '*' clear, 'A' backspace, '#' submit).
module keypad_entry_ctrl #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  key_code,
  output logic        key_strobe,
  output logic [4:0]  last_key,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        entry_valid,
  output logic [15:0] entry_code,
  output logic        error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

  localparam logic [4:0] KEY_NONE = 5'b11111;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'b10000;
  localparam logic [4:0] KEY_ZERO = 5'b10001;
  localparam logic [4:0] KEY_HASH = 5'b10010;

  state_t     state, state_n;
  logic [4:0] cand, cand_n;
  logic [3:0] stab_cnt, stab_n;
  logic [3:0] rel_cnt, rel_n;
  logic       key_valid;
  logic       accept;
  logic [3:0] bcd;

  // Codes 0, 14, 15 and 19..30 carry no key and behave exactly like "none".
  assign key_valid = ((key_code >= 5'd1) && (key_code <= 5'd13)) ||
                     ((key_code >= 5'd16) && (key_code <= 5'd18));

  assign bcd       = (cand == KEY_ZERO) ? 4'd0 : cand[3:0];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand     <= KEY_NONE;
      stab_cnt <= 4'd0;
      rel_cnt  <= 4'd0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      stab_cnt <= stab_n;
      rel_cnt  <= rel_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    stab_n  = stab_cnt;
    rel_n   = rel_cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          cand_n  = key_code;
          stab_n  = 4'd1;
          state_n = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!key_valid) begin
          stab_n  = 4'd0;
          state_n = IDLE;
        end else if (key_code == cand) begin
          // This sample is the STABLE_CYCLES-th identical one.
          if (stab_cnt >= STABLE_M1) begin
            accept  = 1'b1;
            stab_n  = STABLE;
            state_n = HELD;
          end else begin
            stab_n = stab_cnt + 4'd1;
          end
        end else begin
          cand_n = key_code;
          stab_n = 4'd1;
        end
      end
      HELD: begin
        if (!key_valid) begin
          rel_n   = 4'd1;
          state_n = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (key_valid) begin
          rel_n   = 4'd0;
          state_n = HELD;
        end else if (rel_cnt >= STABLE_M1) begin
          rel_n   = STABLE;
          stab_n  = 4'd0;
          state_n = IDLE;
        end else begin
          rel_n = rel_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Entry buffer and output pulses, all registered off the accept decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_strobe  <= 1'b0;
      last_key    <= KEY_NONE;
      digits      <= 16'h0000;
      digit_count <= 3'd0;
      entry_valid <= 1'b0;
      entry_code  <= 16'h0000;
      error       <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      entry_valid <= 1'b0;
      error       <= 1'b0;
      if (accept) begin
        key_strobe <= 1'b1;
        last_key   <= cand;
        case (cand)
          KEY_STAR: begin
            digits      <= 16'h0000;
            digit_count <= 3'd0;
          end
          KEY_HASH: begin
            if (digit_count == 3'd4) begin
              entry_valid <= 1'b1;
              entry_code  <= digits;
              digits      <= 16'h0000;
              digit_count <= 3'd0;
            end else begin
              error <= 1'b1;
            end
          end
          KEY_A: begin
            if (digit_count != 3'd0) begin
              digits      <= {4'h0, digits[15:4]};
              digit_count <= digit_count - 3'd1;
            end else begin
              error <= 1'b1;
            end
          end
          KEY_B, KEY_C, KEY_D: begin
          end
          default: begin
            if (digit_count < 3'd4) begin
              digits      <= {digits[11:0], bcd};
              digit_count <= digit_count + 3'd1;
            end else begin
              error <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: entry/submit, bounce rejection,
// overflow, backspace, hold-and-switch and reset-while-held scenarios.
module tb_keypad_entry_ctrl;

  localparam logic [4:0] NONE = 5'b11111;
  localparam logic [4:0] STAR = 5'b10000;
  localparam logic [4:0] ZERO = 5'b10001;
  localparam logic [4:0] HASH = 5'b10010;
  localparam logic [4:0] KA   = 5'd10;
  localparam logic [4:0] KB   = 5'd11;

  logic        clk;
  logic        rst_n;
  logic [4:0]  key_code;
  logic        key_strobe;
  logic [4:0]  last_key;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        entry_valid;
  logic [15:0] entry_code;
  logic        error;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int errors   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int n_ev     = 0;
  int n_both   = 0;

  keypad_entry_ctrl #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .last_key    (last_key),
    .digits      (digits),
    .digit_count (digit_count),
    .entry_valid (entry_valid),
    .entry_code  (entry_code),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one code for n cycles; outputs are sampled on the falling edge.
  task automatic step(input logic [4:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      key_code = code;
      @(negedge clk);
      if (key_strobe) n_strobe++;
      if (error) n_err++;
      if (entry_valid) n_ev++;
      if (error && entry_valid) n_both++;
    end
  endtask

  task automatic press(input logic [4:0] code);
    step(code, 6);
    step(NONE, 6);
  endtask

  task automatic clr_counts();
    n_strobe = 0;
    n_err    = 0;
    n_ev     = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    key_code = NONE;
    @(negedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_entry_code", 32'(entry_code), 32'h0);
    chk("rst_last_key", 32'(last_key), 32'h1f);
    chk("rst_pulses", 32'({key_strobe, entry_valid, error}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step(NONE, 2);

    // entry 1,2,3,4 then submit
    clr_counts();
    press(5'd1); press(5'd2); press(5'd3); press(5'd4);
    chk("entry_strobes", 32'(n_strobe), 32'd4);
    chk("entry_digits", 32'(digits), 32'h1234);
    chk("entry_count", 32'(digit_count), 32'd4);
    step(HASH, 4);
    chk("submit_valid", 32'(entry_valid), 32'd1);
    chk("submit_code", 32'(entry_code), 32'h1234);
    chk("submit_digits", 32'(digits), 32'h0);
    chk("submit_count", 32'(digit_count), 32'd0);
    step(HASH, 2);
    step(NONE, 6);
    chk("submit_pulses", 32'(n_ev), 32'd1);
    chk("submit_no_err", 32'(n_err), 32'd0);
    chk("submit_strobes", 32'(n_strobe), 32'd5);

    // bounce rejection
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      step(5'd5, 1);
      step(NONE, 1);
    end
    chk("bounce_strobes", 32'(n_strobe), 32'd0);
    chk("bounce_state", 32'(dbg_state), 32'd0);
    step(5'd5, 4);
    chk("stable_strobe_now", 32'(key_strobe), 32'd1);
    chk("stable_strobes", 32'(n_strobe), 32'd1);
    chk("stable_digits", 32'(digits), 32'h0005);
    step(NONE, 6);

    // overflow and short submit
    press(STAR);
    clr_counts();
    press(5'd9); press(5'd9); press(5'd9); press(5'd9); press(5'd7);
    chk("ovf_err", 32'(n_err), 32'd1);
    chk("ovf_digits", 32'(digits), 32'h9999);
    chk("ovf_count", 32'(digit_count), 32'd4);
    chk("ovf_last_key", 32'(last_key), 32'd7);
    chk("ovf_strobes", 32'(n_strobe), 32'd5);
    clr_counts();
    press(STAR);
    chk("star_digits", 32'(digits), 32'h0);
    chk("star_count", 32'(digit_count), 32'd0);
    chk("star_no_err", 32'(n_err), 32'd0);
    press(HASH);
    chk("short_err", 32'(n_err), 32'd1);
    chk("short_no_valid", 32'(n_ev), 32'd0);
    chk("short_count", 32'(digit_count), 32'd0);

    // backspace
    clr_counts();
    press(ZERO); press(5'd8);
    chk("bs_pre_digits", 32'(digits), 32'h0008);
    press(KA);
    chk("bs1_digits", 32'(digits), 32'h0000);
    chk("bs1_count", 32'(digit_count), 32'd1);
    press(KA);
    chk("bs2_count", 32'(digit_count), 32'd0);
    chk("bs2_no_err", 32'(n_err), 32'd0);
    press(KA);
    chk("bs3_err", 32'(n_err), 32'd1);
    press(KB);
    chk("keyb_last_key", 32'(last_key), 32'(KB));
    chk("keyb_no_err", 32'(n_err), 32'd1);
    chk("keyb_count", 32'(digit_count), 32'd0);
    chk("bs_strobes", 32'(n_strobe), 32'd6);

    // hold and switch
    clr_counts();
    step(5'd3, 4);
    step(5'd6, 10);
    step(NONE, 4);
    chk("switch_strobes", 32'(n_strobe), 32'd1);
    chk("switch_last_key", 32'(last_key), 32'd3);
    chk("switch_state", 32'(dbg_state), 32'd0);
    chk("switch_digits", 32'(digits), 32'h0003);
    step(NONE, 2);

    // reset while held
    step(5'd2, 6);
    chk("held_digits", 32'(digits), 32'h0032);
    rst_n = 1'b0;
    step(5'd2, 1);
    chk("mid_rst_digits", 32'(digits), 32'h0);
    chk("mid_rst_count", 32'(digit_count), 32'd0);
    chk("mid_rst_entry_code", 32'(entry_code), 32'h0);
    chk("mid_rst_last_key", 32'(last_key), 32'h1f);
    chk("mid_rst_pulses", 32'({key_strobe, entry_valid, error}), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    clr_counts();
    step(5'd2, 3);
    chk("post_rst_early", 32'(n_strobe), 32'd0);
    step(5'd2, 1);
    chk("post_rst_strobe_now", 32'(key_strobe), 32'd1);
    chk("post_rst_digits", 32'(digits), 32'h0002);
    step(5'd2, 4);
    step(NONE, 6);
    chk("post_rst_strobes", 32'(n_strobe), 32'd1);
    chk("never_both", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical key_code samples needed to accept a press or a release (range 2..15).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port key_code  input  5  decoded key from the keypad scanner; 5'b11111 = no key.
REQ-005 SHALL have port key_strobe  output  1  one-cycle pulse per accepted press.
REQ-006 SHALL have port last_key  output  5  code of the most recently accepted press.
REQ-007 SHALL have port digits  output  16  entry buffer, 4 BCD nibbles, newest digit in [3:0].
REQ-008 SHALL have port digit_count  output  3  number of digits in the buffer, 0..4.
REQ-009 SHALL have port entry_valid  output  1  one-cycle pulse when a complete 4-digit entry is submitted.
REQ-010 SHALL have port entry_code  output  16  submitted entry; held until the next submission.
REQ-011 SHALL have port error  output  1  one-cycle pulse on a rejected key.

Function
REQ-012 Key codes SHALL be: 1-9 = 5'd1-5'd9; 0 = 5'b10001; A-D = 5'd10-5'd13; * = 5'b10000; # = 5'b10010; 5'b11111 = none; 5'd0 and 5'b10011-5'b11110 invalid, treated as none.
REQ-013 The debounce FSM SHALL have the states IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-014 IDLE: on a valid key code, the FSM SHALL latch it as the candidate, load stable count = 1 and go to PRESS_DB.
REQ-015 PRESS_DB: while key_code equals the candidate, the FSM SHALL increment the stable count.
REQ-016 PRESS_DB: when the stable count reaches STABLE_CYCLES, the FSM SHALL accept the candidate and go to HELD.
REQ-017 PRESS_DB: on a different valid code, the FSM SHALL re-latch the candidate with count = 1 and stay in PRESS_DB.
REQ-018 PRESS_DB: on none, the FSM SHALL return to IDLE with no accept.
REQ-019 HELD: on none, the FSM SHALL load release count = 1 and go to RELEASE_DB; any valid code, including a different key, SHALL be ignored.
REQ-020 RELEASE_DB: on consecutive none samples reaching STABLE_CYCLES, the FSM SHALL go to IDLE.
REQ-021 RELEASE_DB: on any valid code, the FSM SHALL return to HELD; no new accept SHALL occur without a full release.
REQ-022 Accept latency SHALL be as follows: key_strobe, last_key and all buffer effects are registered and visible the cycle after the sample that completes STABLE_CYCLES; minimum press-to-strobe latency = STABLE_CYCLES cycles.
REQ-023 Digit accept: if digit_count < 4, the block SHALL perform digits <= {digits[11:0], BCD} and digit_count++; if digit_count == 4, buffer SHALL be unchanged and error pulses.
REQ-024 The BCD value SHALL be key_code[3:0] for 1-9 and 4'd0 for key 0.
REQ-025 '*' SHALL clear digits to 16'h0000 and digit_count to 0, with no error even if the buffer is already empty.
REQ-026 'A' (backspace): if digit_count > 0, the block SHALL perform digits <= {4'h0, digits[15:4]} and digit_count--; otherwise error pulses.
REQ-027 '#': if digit_count == 4, the block SHALL assert entry_valid, set entry_code <= digits, and clear the buffer, all in the same cycle.
REQ-028 '#': if digit_count != 4, error SHALL pulse and the buffer SHALL be unchanged.
REQ-029 'B', 'C', 'D' SHALL strobe key_strobe and update last_key only, with no buffer change and no error.
REQ-030 key_strobe SHALL pulse for every accepted key, including rejected ones; entry_valid and error SHALL never be asserted together.
REQ-031 The stable and release counters SHALL be 4-bit and saturate at STABLE_CYCLES; no wrap-around.

Reset
REQ-032 While rst_n = 0 at a clk edge, the FSM SHALL go to IDLE and the counters and candidate SHALL clear.
REQ-033 Reset values SHALL be: digits = 16'h0000, digit_count = 0, entry_code = 16'h0000, last_key = 5'b11111, key_strobe = entry_valid = error = 0.
REQ-034 Reset mid-debounce or while HELD SHALL discard the press; after reset the same still-held key SHALL be accepted once, after STABLE_CYCLES stable samples.

Verification
REQ-035 The bench SHALL check the entry sequence: keys 1,2,3,4,# each held 6 cycles, released 6 cycles -> four strobes, digits = 16'h1234, count = 4; on '#' entry_valid for 1 cycle, entry_code = 16'h1234, digits = 0, count = 0.
REQ-036 The bench SHALL check bounce rejection: key_code alternates 5'd5 / 5'b11111 every cycle for 20 cycles -> no key_strobe; then 5'd5 held 4 cycles -> exactly one strobe, digits = 16'h0005.
REQ-037 The bench SHALL check overflow and short submit: keys 9,9,9,9,7 -> fifth key gives error, digits = 16'h9999; '*', then '#' with count 0 -> error, no entry_valid.
REQ-038 The bench SHALL check backspace: keys 0,8,A -> digits = 16'h0000, count = 1; A again -> count = 0; A again -> error.
REQ-039 The bench SHALL check hold and switch: 5'd3 held 4 cycles, then changed directly to 5'd6 for 10 cycles, then none 4 cycles -> only one strobe (key 3); FSM back in IDLE.
REQ-040 The bench SHALL check reset mid-hold: rst_n low 1 cycle while 5'd2 held in HELD -> all outputs at reset values; 5'd2 still held -> one strobe 4 cycles after reset release.
